// File: rtl/led_mode_ctrl_if.sv
// Pin-level bundle between the board button/LED and led_mode_ctrl.
// The board side (master) drives the raw button; the controller (slave) drives the LED and status.
interface led_mode_ctrl_if;
    logic       Tact1;
    logic       USER_LED1;
    logic [1:0] MODE;
    logic       LED_TICK;

    modport master (
        output Tact1,
        input  USER_LED1,
        input  MODE,
        input  LED_TICK
    );

    modport slave (
        input  Tact1,
        output USER_LED1,
        output MODE,
        output LED_TICK
    );
endinterface

// File: rtl/led_mode_ctrl.sv
// Push-button sequenced LED blinker: synchronize and debounce the button, step a
// 4-state mode on each press, and blink USER_LED1 from a reloadable down-counter.
module led_mode_ctrl #(
    parameter int   W_CNT   = 23,
    parameter int   W_DEB   = 18,
    parameter logic TACT_ON = 1'b0
) (
    input  logic           CLK_24MHz,
    input  logic           RST_N,
    led_mode_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_SLOW = 2'd1,
        MODE_FAST = 2'd2,
        MODE_ON   = 2'd3
    } mode_e;

    localparam logic [W_CNT-1:0] CNT_ONES = '1;
    localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);
    localparam logic [W_DEB-1:0] DEB_ONES = '1;
    localparam logic [W_DEB-1:0] DEB_ONE  = W_DEB'(1);

    logic [1:0]       r_sync;
    logic             w_sample;
    logic             r_btn_db;
    logic             r_btn_db_d;
    logic [W_DEB-1:0] r_deb;
    logic             w_press;
    mode_e            r_mode;
    mode_e            w_mode_nxt;
    logic [W_CNT-1:0] r_cnt;
    logic             r_led;
    logic             r_tick;
    logic             w_blinking;

    // Two-flop synchronizer; reset to the released level so no phantom press.
    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_sync <= {2{~TACT_ON}};
        end else begin
            r_sync <= {r_sync[0], bus.Tact1};
        end
    end

    assign w_sample = (r_sync[1] == TACT_ON);

    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_btn_db   <= 1'b0;
            r_btn_db_d <= 1'b0;
            r_deb      <= '0;
        end else begin
            r_btn_db_d <= r_btn_db;
            if (w_sample == r_btn_db) begin
                r_deb <= '0;
            end else if (r_deb == DEB_ONES) begin
                r_btn_db <= w_sample;
                r_deb    <= '0;
            end else begin
                r_deb <= r_deb + DEB_ONE;
            end
        end
    end

    // Rising edge of the debounced level only; releases are ignored.
    assign w_press = r_btn_db & ~r_btn_db_d;

    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_mode <= MODE_OFF;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (w_press) begin
            unique case (r_mode)
                MODE_OFF:  w_mode_nxt = MODE_SLOW;
                MODE_SLOW: w_mode_nxt = MODE_FAST;
                MODE_FAST: w_mode_nxt = MODE_ON;
                MODE_ON:   w_mode_nxt = MODE_OFF;
            endcase
        end
    end

    function automatic logic [W_CNT-1:0] reload(input mode_e m);
        if (m == MODE_FAST) return CNT_ONES >> 2;
        return CNT_ONES;
    endfunction

    assign w_blinking = (r_mode == MODE_SLOW) || (r_mode == MODE_FAST);

    // A press on the same edge as an expiry takes priority: fresh period, no tick.
    always_ff @(posedge CLK_24MHz or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt  <= CNT_ONES;
            r_led  <= 1'b0;
            r_tick <= 1'b0;
        end else if (w_press) begin
            r_cnt  <= reload(w_mode_nxt);
            r_led  <= (w_mode_nxt != MODE_OFF);
            r_tick <= 1'b0;
        end else if (w_blinking) begin
            if (r_cnt == '0) begin
                r_cnt  <= reload(r_mode);
                r_led  <= ~r_led;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt - CNT_ONE;
                r_tick <= 1'b0;
            end
        end else begin
            r_cnt  <= CNT_ONES;
            r_tick <= 1'b0;
        end
    end

    assign bus.USER_LED1 = r_led;
    assign bus.MODE      = r_mode;
    assign bus.LED_TICK  = r_tick;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Scoreboard bench for led_mode_ctrl at W_CNT=6, W_DEB=4: expected output events are
// queued as the button is driven and popped when the DUT shows an output change or tick.
module tb_led_mode_ctrl;

    localparam int LAT = 19; // drive at negedge c -> first sample edge c+1 -> update edge c+1+18

    typedef struct {
        int         cyc;
        logic [1:0] mode;
        logic       led;
        logic       tick;
    } ev_t;

    logic clk;
    logic RST_N;
    led_mode_ctrl_if bus ();

    led_mode_ctrl #(.W_CNT(6), .W_DEB(4), .TACT_ON(1'b0)) dut (
        .CLK_24MHz (clk),
        .RST_N     (RST_N),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   mon_en = 0;
    ev_t  sb[$];
    ev_t  mon_e;
    logic [1:0] prev_mode = 2'd0;
    logic       prev_led = 1'b0;

    logic [1:0] m_mode;
    logic       m_led;
    int         m_next;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && (bus.LED_TICK !== 1'b0 || bus.MODE !== prev_mode || bus.USER_LED1 !== prev_led)) begin
            n_chk++;
            if (sb.size() == 0) begin
                $display("FAIL unexpected_event cyc=%0d mode=%0d led=%0d tick=%0d (no event expected)",
                         cyc, bus.MODE, bus.USER_LED1, bus.LED_TICK);
            end else begin
                mon_e = sb.pop_front();
                if (cyc !== mon_e.cyc || bus.MODE !== mon_e.mode ||
                    bus.USER_LED1 !== mon_e.led || bus.LED_TICK !== mon_e.tick)
                    $display("FAIL event got cyc=%0d mode=%0d led=%0d tick=%0d, want cyc=%0d mode=%0d led=%0d tick=%0d",
                             cyc, bus.MODE, bus.USER_LED1, bus.LED_TICK,
                             mon_e.cyc, mon_e.mode, mon_e.led, mon_e.tick);
                else
                    n_pass++;
            end
        end
        prev_mode = bus.MODE;
        prev_led  = bus.USER_LED1;
    end

    function automatic int ivl(input logic [1:0] m);
        if (m == 2'd1) return 64;
        if (m == 2'd2) return 16;
        return 0;
    endfunction

    task automatic push_ev(input int c, input logic [1:0] m, input logic l, input logic t);
        ev_t e;
        e.cyc = c; e.mode = m; e.led = l; e.tick = t;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_mode = 2'd0;
        m_led  = 1'b0;
        m_next = 0;
    endtask

    task automatic run_model_until(input int t);
        while ((m_mode == 2'd1 || m_mode == 2'd2) && m_next <= t) begin
            m_led = ~m_led;
            push_ev(m_next, m_mode, m_led, 1'b1);
            m_next += ivl(m_mode);
        end
    endtask

    // Press edge p replaces any toggle due on p.
    task automatic model_press(input int p);
        run_model_until(p - 1);
        m_mode = m_mode + 2'd1;
        m_led  = (m_mode != 2'd0);
        push_ev(p, m_mode, m_led, 1'b0);
        m_next = p + ivl(m_mode);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            run_model_until(cyc + 1);
        end
    endtask

    task automatic press(input int hold, input int gap, output int c);
        @(negedge clk);
        run_model_until(cyc + 1);
        c = cyc;
        bus.Tact1 = 1'b0;
        model_press(c + LAT);
        tick(hold);
        bus.Tact1 = 1'b1;
        tick(gap);
    endtask

    task automatic apply_reset();
        int due = 0;
        foreach (sb[i]) if (sb[i].cyc <= cyc) due++;
        n_chk++;
        if (due !== 0) $display("FAIL missed_events got %0d overdue, want 0", due);
        else n_pass++;
        mon_en = 0;
        @(negedge clk);
        RST_N = 1'b0;
        bus.Tact1 = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.MODE, bus.USER_LED1, bus.LED_TICK} !== 4'b0000)
            $display("FAIL reset_outputs got mode=%0d led=%0d tick=%0d, want 0/0/0",
                     bus.MODE, bus.USER_LED1, bus.LED_TICK);
        else n_pass++;
        model_reset();
        sb.delete();
        RST_N = 1'b1;
        mon_en = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        tick(200);
        n_chk++;
        if (bus.MODE !== 2'd0 || bus.USER_LED1 !== 1'b0)
            $display("FAIL idle got mode=%0d led=%0d, want 0/0", bus.MODE, bus.USER_LED1);
        else n_pass++;
    endtask

    task automatic test_hold();
        int c;
        apply_reset();
        press(100, 70, c);
        n_chk++;
        if (bus.MODE !== 2'd1)
            $display("FAIL hold_mode got %0d, want 1", bus.MODE);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int c;
        apply_reset();
        bus.Tact1 = 1'b0;
        tick(10);
        bus.Tact1 = 1'b1;
        tick(40);
        n_chk++;
        if (bus.MODE !== 2'd0)
            $display("FAIL short_glitch_mode got %0d, want 0", bus.MODE);
        else n_pass++;
        for (int i = 0; i < 20; i++) begin
            bus.Tact1 = (i % 2 == 1);
            tick(3);
        end
        n_chk++;
        if (bus.MODE !== 2'd0)
            $display("FAIL bounce_mode got %0d, want 0", bus.MODE);
        else n_pass++;
        press(30, 20, c);
        n_chk++;
        if (bus.MODE !== 2'd1)
            $display("FAIL bounce_then_low_mode got %0d, want 1", bus.MODE);
        else n_pass++;
    endtask

    task automatic test_cycle();
        int c;
        apply_reset();
        press(25, 150, c);
        press(25, 60, c);
        n_chk++;
        if (bus.MODE !== 2'd2)
            $display("FAIL cycle_fast got %0d, want 2", bus.MODE);
        else n_pass++;
        press(25, 60, c);
        n_chk++;
        if (bus.MODE !== 2'd3 || bus.USER_LED1 !== 1'b1)
            $display("FAIL cycle_on got mode=%0d led=%0d, want 3/1", bus.MODE, bus.USER_LED1);
        else n_pass++;
        press(25, 40, c);
        n_chk++;
        if (bus.MODE !== 2'd0 || bus.USER_LED1 !== 1'b0)
            $display("FAIL cycle_off got mode=%0d led=%0d, want 0/0", bus.MODE, bus.USER_LED1);
        else n_pass++;
    endtask

    task automatic test_collision();
        int c0, c2;
        apply_reset();
        press(25, 0, c0);
        while (cyc < c0 + 127) tick(1);
        // second press edge lands exactly on the second SLOW expiry
        press(25, 40, c2);
        n_chk++;
        if (c2 !== c0 + 128)
            $display("FAIL collision_align got start=%0d, want %0d", c2, c0 + 128);
        else n_pass++;
        n_chk++;
        if (bus.MODE !== 2'd2)
            $display("FAIL collision_mode got %0d, want 2", bus.MODE);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int c;
        apply_reset();
        press(25, 30, c);
        press(25, 30, c);
        tick(5);
        @(posedge clk);
        #3;
        mon_en = 0;
        RST_N = 1'b0;
        #1;
        n_chk++;
        if ({bus.MODE, bus.USER_LED1, bus.LED_TICK} !== 4'b0000)
            $display("FAIL async_reset got mode=%0d led=%0d tick=%0d, want 0/0/0",
                     bus.MODE, bus.USER_LED1, bus.LED_TICK);
        else n_pass++;
        repeat (2) @(negedge clk);
        model_reset();
        sb.delete();
        RST_N = 1'b1;
        mon_en = 1;
        press(25, 30, c);
        n_chk++;
        if (bus.MODE !== 2'd1)
            $display("FAIL after_async_mode got %0d, want 1", bus.MODE);
        else n_pass++;
    endtask

    initial begin
        RST_N = 1'b0;
        bus.Tact1 = 1'b1;
        model_reset();
        test_reset();
        test_hold();
        test_glitch();
        test_cycle();
        test_collision();
        test_async_reset();
        apply_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
